fc_out_serializer: RTL

Converts one parallel FC result vector (`NUM_NEURONS` accumulators plus a one-cycle valid pulse) into a serial element stream for the next layer's serial input port. It applies optional ReLU, then requantizes and saturates each accumulator to `DATA_WIDTH`. Elements leave one per cycle under valid/ready backpressure. It sits between an FC layer's parallel output and the following layer's `in_valid`/`data_in` input.

---
 rtl/fc_pkg.sv | 23 ++
 rtl/fc_requant.sv | 39 +++
 rtl/fc_out_serializer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC output serializer: FSM state encoding
// and signed saturation bounds derived from an output element width.
package fc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fc_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic longint sat_max(input int dw);
        return (longint'(1) << (dw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

    localparam longint DEFAULT_SAT_MAX = sat_max(DEFAULT_DATA_WIDTH);
    localparam longint DEFAULT_SAT_MIN = sat_min(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/fc_requant.sv
// Combinational single-element requantizer: optional ReLU, round-half-up,
// arithmetic right shift and saturation to a signed DATA_WIDTH result.
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT      = 8,
    parameter int RELU_EN    = 1
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] q
);

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    localparam logic signed [ACC_WIDTH:0] RND     = ((ACC_WIDTH+1)'(1) << SHIFT) >>> 1;
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH:0] x;
    logic signed [ACC_WIDTH:0] rounded;
    logic signed [ACC_WIDTH:0] shifted;

    always_comb begin
        x = $signed({acc[ACC_WIDTH-1], acc});
        if ((RELU_EN != 0) && acc[ACC_WIDTH-1]) begin
            x = '0;
        end
        rounded = x + RND;
        shifted = rounded >>> SHIFT;
        q       = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            q = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            q = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fc_out_serializer.sv
// Serializes one parallel FC result vector into a requantized element stream,
// with a one-deep pending slot so a following vector can stream without a bubble.
module fc_out_serializer
    import fc_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT       = 8,
    parameter int RELU_EN     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [NUM_NEURONS*ACC_WIDTH-1:0] in_vec,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             overflow
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    fc_state_t                        state_reg;
    logic [NUM_NEURONS*ACC_WIDTH-1:0] active_vec_reg;
    logic [NUM_NEURONS*ACC_WIDTH-1:0] pending_vec_reg;
    logic                             pending_full_reg;
    logic [IDX_W-1:0]                 idx_reg;
    logic                             out_valid_reg;
    logic [DATA_WIDTH-1:0]            out_data_reg;
    logic                             out_last_reg;
    logic                             overflow_reg;

    logic [ACC_WIDTH-1:0] active_elem [NUM_NEURONS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_unpack
            assign active_elem[gi] = active_vec_reg[gi*ACC_WIDTH +: ACC_WIDTH];
        end
    endgenerate

    logic                  hs;
    logic                  last_hs;
    logic                  capture;
    logic                  take_active;
    logic                  take_pending;
    logic                  promote;
    logic [IDX_W-1:0]      next_idx;
    logic [ACC_WIDTH-1:0]  rq_src;
    logic [DATA_WIDTH-1:0] rq_q;

    assign hs           = out_valid_reg && out_ready;
    assign last_hs      = hs && out_last_reg;
    assign capture      = in_valid && !pending_full_reg;
    // A fresh vector bypasses PENDING whenever ACTIVE is free or is freeing up now.
    assign take_active  = capture && ((state_reg == IDLE) || last_hs);
    assign take_pending = capture && !take_active;
    assign promote      = last_hs && pending_full_reg;
    assign next_idx     = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

    // One requantizer serves every load: new vector, promoted vector or next element.
    always_comb begin
        rq_src = active_elem[next_idx];
        if (take_active) begin
            rq_src = in_vec[ACC_WIDTH-1:0];
        end else if (promote) begin
            rq_src = pending_vec_reg[ACC_WIDTH-1:0];
        end
    end

    fc_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .SHIFT     (SHIFT),
        .RELU_EN   (RELU_EN)
    ) u_requant (
        .acc(rq_src),
        .q  (rq_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            active_vec_reg   <= '0;
            pending_vec_reg  <= '0;
            pending_full_reg <= 1'b0;
            idx_reg          <= '0;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_last_reg     <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            if (in_valid && pending_full_reg) begin
                overflow_reg <= 1'b1;
            end
            if (take_pending) begin
                pending_vec_reg  <= in_vec;
                pending_full_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (take_active) begin
                        active_vec_reg <= in_vec;
                        idx_reg        <= '0;
                        out_valid_reg  <= 1'b1;
                        out_data_reg   <= rq_q;
                        out_last_reg   <= (LAST_IDX == '0);
                        state_reg      <= SEND;
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        idx_reg <= '0;
                        if (take_active) begin
                            active_vec_reg <= in_vec;
                            out_data_reg   <= rq_q;
                            out_last_reg   <= (LAST_IDX == '0);
                        end else if (promote) begin
                            active_vec_reg   <= pending_vec_reg;
                            pending_full_reg <= 1'b0;
                            out_data_reg     <= rq_q;
                            out_last_reg     <= (LAST_IDX == '0);
                        end else begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            state_reg     <= IDLE;
                        end
                    end else if (hs) begin
                        idx_reg      <= next_idx;
                        out_data_reg <= rq_q;
                        out_last_reg <= (next_idx == LAST_IDX);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = !pending_full_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign overflow  = overflow_reg;

endmodule
